// File: rtl/slow_tick_monitor_pkg.sv
// Shared quiz definitions: monitor state encoding, divider-derived defaults and
// the half-period tolerance window check.
package slow_tick_monitor_pkg;

  localparam int unsigned ST_W = 2;

  localparam logic [1:0] ST_ACQUIRE = 2'd0;
  localparam logic [1:0] ST_LOCKED  = 2'd1;
  localparam logic [1:0] ST_LOST    = 2'd2;

  // The divider toggles after counting 0..DIV_TERMINAL, so one half-period spans terminal+1 clocks
  localparam int unsigned DIV_TERMINAL    = 4;
  localparam int unsigned EXPECT_HALF_DEF = DIV_TERMINAL + 1;

  function automatic logic half_match(input int unsigned meas,
                                      input int unsigned exp_half,
                                      input int unsigned tol);
    int unsigned lo;
    lo = (exp_half > tol) ? (exp_half - tol) : 32'd0;
    return (meas >= lo) && (meas <= (exp_half + tol));
  endfunction

endpackage

// File: rtl/slow_tick_monitor_sync_edge_det.sv
// Two-flop synchronizer with edge detection; exposes the same-cycle edge strobes
// and their registered single-cycle pulses. Also used for the quiz push-buttons.
module sync_edge_det (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_din,
  output logic o_rise_c,
  output logic o_fall_c,
  output logic o_rise,
  output logic o_fall
);

  logic r_s1;
  logic r_s2;
  logic r_s3;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_s1   <= 1'b0;
      r_s2   <= 1'b0;
      r_s3   <= 1'b0;
      o_rise <= 1'b0;
      o_fall <= 1'b0;
    end else begin
      r_s1   <= i_din;
      r_s2   <= r_s1;
      r_s3   <= r_s2;
      o_rise <= o_rise_c;
      o_fall <= o_fall_c;
    end
  end

  assign o_rise_c = r_s2 & ~r_s3;
  assign o_fall_c = ~r_s2 & r_s3;

endmodule

// File: rtl/slow_tick_monitor.sv
// Turns the divided quiz clock into tick enables and tracks its half-period,
// reporting lock, loss of toggling and period errors.
module slow_tick_monitor
  import slow_tick_monitor_pkg::*;
#(
  parameter int unsigned CNT_W       = 8,
  parameter int unsigned EXPECT_HALF = EXPECT_HALF_DEF,
  parameter int unsigned TOL         = 0,
  parameter int unsigned LOCK_COUNT  = 4,
  parameter int unsigned TIMEOUT     = 32
) (
  input  logic             clk_in,
  input  logic             reset,
  input  logic             slow_in,
  output logic             tick_rise,
  output logic             tick_fall,
  output logic [CNT_W-1:0] half_period,
  output logic             period_valid,
  output logic             locked,
  output logic             lost,
  output logic             period_err
);

  localparam int unsigned      MC_W    = $clog2(LOCK_COUNT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

  logic             w_rise_c;
  logic             w_fall_c;
  logic             w_edge;
  logic             w_match;
  logic [CNT_W:0]   w_meas;
  logic [CNT_W-1:0] w_meas_sat;

  logic [ST_W-1:0]  r_state;
  logic [ST_W-1:0]  w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [MC_W-1:0]  r_match_cnt;
  logic [MC_W-1:0]  w_match_nxt;
  logic             r_first;
  logic             w_first_nxt;
  logic             w_pv_nxt;
  logic             w_err_nxt;
  logic [CNT_W-1:0] w_hp_nxt;

  sync_edge_det u_sync (
    .i_clk    (clk_in),
    .i_rst_n  (reset),
    .i_din    (slow_in),
    .o_rise_c (w_rise_c),
    .o_fall_c (w_fall_c),
    .o_rise   (tick_rise),
    .o_fall   (tick_fall)
  );

  assign w_edge     = w_rise_c | w_fall_c;
  assign w_meas     = {1'b0, r_cnt} + (CNT_W + 1)'(1);
  assign w_meas_sat = w_meas[CNT_W] ? CNT_MAX : w_meas[CNT_W-1:0];
  assign w_match    = half_match(32'(w_meas), EXPECT_HALF, TOL);

  // Next-state, counter and capture decisions; an edge always wins over the timeout
  always_comb begin
    w_state_nxt = r_state;
    w_match_nxt = r_match_cnt;
    w_first_nxt = r_first;
    w_pv_nxt    = 1'b0;
    w_err_nxt   = 1'b0;
    w_hp_nxt    = half_period;
    w_cnt_nxt   = (r_cnt == CNT_MAX) ? r_cnt : (r_cnt + CNT_W'(1));

    if (w_edge) begin
      w_cnt_nxt = '0;
      if (r_first) begin
        w_first_nxt = 1'b0;
        if (r_state == ST_LOST) begin
          w_state_nxt = ST_ACQUIRE;
        end
      end else begin
        w_pv_nxt = 1'b1;
        w_hp_nxt = w_meas_sat;
        case (r_state)
          ST_ACQUIRE: begin
            if (!w_match) begin
              w_match_nxt = '0;
            end else if (r_match_cnt == MC_W'(LOCK_COUNT - 1)) begin
              w_state_nxt = ST_LOCKED;
              w_match_nxt = '0;
            end else begin
              w_match_nxt = r_match_cnt + MC_W'(1);
            end
          end
          ST_LOCKED: begin
            if (!w_match) begin
              w_err_nxt   = 1'b1;
              w_state_nxt = ST_ACQUIRE;
              w_match_nxt = '0;
            end
          end
          default: begin
            w_state_nxt = ST_ACQUIRE;
            w_match_nxt = '0;
          end
        endcase
      end
    end else if (r_cnt == TO_LAST) begin
      w_state_nxt = ST_LOST;
      w_match_nxt = '0;
      w_first_nxt = 1'b1;
    end
  end

  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      r_state      <= ST_ACQUIRE;
      r_cnt        <= '0;
      r_match_cnt  <= '0;
      r_first      <= 1'b1;
      half_period  <= '0;
      period_valid <= 1'b0;
      period_err   <= 1'b0;
      locked       <= 1'b0;
      lost         <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_match_cnt  <= w_match_nxt;
      r_first      <= w_first_nxt;
      half_period  <= w_hp_nxt;
      period_valid <= w_pv_nxt;
      period_err   <= w_err_nxt;
      locked       <= (w_state_nxt == ST_LOCKED);
      lost         <= (w_state_nxt == ST_LOST);
    end
  end

endmodule
